// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload expiry, level irq gated by CTRL.IM.
module timer_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en_eff;

  assign sel       = addr[3:2];
  assign wr_ctrl   = we && (sel == 2'b00);
  assign wr_preset = we && (sel == 2'b01);
  // A same-cycle CTRL write decides whether a running count keeps going.
  assign en_eff    = wr_ctrl ? wd[0] : ctrl_q[0];

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = wr_preset ? wd : preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_eff) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          flag_d  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        if (ctrl_q[2:1] == 2'b01) flag_d = 1'b0;
        else                      ctrl_d[0] = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Software CTRL writes take priority over the FSM's own EN/flag updates.
    if (wr_ctrl) begin
      ctrl_d = wd[3:0];
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rd = 32'd0;
    case (sel)
      2'b00:   rd = {28'd0, ctrl_q};
      2'b01:   rd = preset_q;
      2'b10:   rd = count_q;
      default: rd = 32'd0;
    endcase
  end

  assign irq = ctrl_q[3] & flag_q;

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer placed directly downstream of the CPU-side address bridge. Each of the two timer windows, 0x7f00–0x7f0b and 0x7f10–0x7f1b, gets one instance. The bridge drives the instance's address, write-enable and write data, and routes its read data back onto the processor read bus. The block raises a level interrupt request toward the CP0 interrupt inputs when the count expires, in either one-shot mode or auto-reload mode.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- addr  in  32  byte address from the bridge; only addr[3:2] is decoded: 00 CTRL, 01 PRESET, 10 COUNT, 11 reserved.
- we  in  1  word write strobe, already qualified by the bridge hit; sampled on the clk edge.
- wd  in  32  write data.
- rd  out  32  combinational read data for the register selected by addr[3:2].
- irq  out  1  interrupt request, equal to CTRL.IM & irq_flag.

## Operation
- Registers:
  - CTRL[3:0]: bit 3 IM (interrupt mask), bits 2:1 MODE, bit 0 EN. Bits 31:4 read as 0.
  - PRESET[31:0]: read/write.
  - COUNT[31:0]: read-only; writes are ignored.
  - Reserved offset 0xC reads 0 and ignores writes.
- Bus writes:
  - CTRL write: CTRL <= wd[3:0], and irq_flag is cleared.
  - PRESET write: PRESET <= wd.
  - A bus write to CTRL overrides any FSM update of CTRL.EN in the same cycle.
- FSM, with states IDLE, LOAD, CNT and INT:
  - IDLE: if EN=1, go to LOAD; otherwise stay in IDLE. COUNT holds.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - EN=0: go to IDLE; COUNT freezes.
    - COUNT > 1: COUNT <= COUNT − 1.
    - COUNT ≤ 1: COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE=00: EN <= 0, go to IDLE; irq_flag stays set until software writes CTRL.
  - INT, MODE=01: irq_flag <= 0, go to IDLE; because EN is still set, the counter reloads automatically.
  - MODE 10 and 11 behave as 00.
- Arithmetic: unsigned 32-bit. The counter never decrements below 0 and never wraps.
- PRESET=0 behaves the same as PRESET=1.
- A write to PRESET during CNT does not affect the running count; it takes effect at the next LOAD.
- Reset (asynchronous, any state): state=IDLE, CTRL=0, PRESET=0, COUNT=0, irq_flag=0. So rd reads 0 at every offset and irq=0. A reset asserted mid-count aborts the count with no interrupt.

## Timing
- rd is combinational from addr and the current register values; a write at edge e is visible on rd after e.
- Let e0 be the edge that writes EN=1 in IDLE, and let N=max(PRESET,1):
  - e1: state becomes LOAD.
  - e2: COUNT=PRESET, state becomes CNT.
  - e(2+k): COUNT=N−k.
  - e(N+2): COUNT=0, state becomes INT, irq_flag=1.
- Mode 0: from e(N+3), EN=0 and the block idles. irq stays high (when IM=1) until a CTRL write.
- Mode 1: irq is high for exactly one cycle, from e(N+2) to e(N+3).
  - The next LOAD occurs at e(N+4), and COUNT=PRESET again at e(N+5).
  - The interrupt period is N+3 cycles.
- Clearing EN while in CNT: the state returns to IDLE at the same edge as the write, or one edge later, and COUNT holds its last value.
- Setting EN again restarts from LOAD, taking a fresh PRESET.
- A CTRL write landing on the INT cycle wins: the written EN value persists and irq_flag is cleared.

## Test plan
- Reset: assert rst_n=0 with no clock running -> rd=0 at all offsets, irq=0. Release reset and hold 10 cycles -> COUNT stays 0.
- One-shot: write PRESET=5, then CTRL=0x9 (IM=1, MODE=00, EN=1) at e0:
  - COUNT reads 5,4,3,2,1 at e2..e6 and becomes 0 at e7, when irq rises.
  - irq stays 1 for 20 cycles, and CTRL reads 0x8.
  - Writing CTRL=0 drops irq on the next edge.
- Auto-reload: write PRESET=3, then CTRL=0xB:
  - irq pulses for one cycle at e5, e11 and e17 (period 6).
  - COUNT sequence is 3,2,1,0,…
- Mask: write PRESET=2, then CTRL=0x1 -> irq stays 0 throughout and COUNT reaches 0 at e4. A later write of CTRL=0x8 also leaves irq at 0, because the CTRL write clears irq_flag.
- Pause/resume: with PRESET=10 and CTRL=0x9, write CTRL=0x8 when COUNT=6:
  - COUNT holds at 6.
  - Rewriting CTRL=0x9 reloads 10, and irq fires 12 cycles after that write.
- Edge cases:
  - PRESET=0 with CTRL=0x9 -> irq at e3.
  - Writes to COUNT and to offset 0xC are ignored, and offset 0xC reads 0.
  - Asserting reset mid-count at COUNT=4 returns all registers to 0 with no irq.
